alu_op_sequencer: RTL and testbench

Multi-cycle issuing controller on the initiator side of the ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's 5-bit function select. It holds that select stable across the ALU's registered result and flag stages, then captures the result and the Z|C|N|V flags. It returns them over a second valid/ready handshake to the register-file/control datapath.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_seq_fsm.sv | 45 ++++
 rtl/alu_op_sequencer.sv | 108 ++++++++++
 tb/tb_alu_op_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: FSM states, ALU function-select codes and flag bit indices for alu_op_sequencer.
// The HI_* states exist only when ALU_SEQ_DBL_ADD_EN is defined.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESULT,
        ST_FLAGS,
        ST_RESP
`ifdef ALU_SEQ_DBL_ADD_EN
        ,
        ST_HI_ISSUE,
        ST_HI_RESULT,
        ST_HI_FLAGS
`endif
    } state_t;

    localparam logic [4:0] FS_PASSA32 = 5'b10000;
    localparam logic [4:0] FS_ADD32   = 5'b10100;
    localparam logic [4:0] FS_ADC32   = 5'b10101;

    localparam int Z = 3;
    localparam int C = 2;
    localparam int N = 1;
    localparam int V = 0;

endpackage

// File: rtl/alu_seq_fsm.sv
// alu_seq_fsm: state register and next-state logic of the ALU issuing sequencer.
// The second (high-word) pass is built only with ALU_SEQ_DBL_ADD_EN.
module alu_seq_fsm
    import alu_seq_pkg::*;
(
    input  logic   i_clock,
    input  logic   i_reset_n,
    input  logic   i_instr_valid,
    input  logic   i_res_ready,
`ifdef ALU_SEQ_DBL_ADD_EN
    input  logic   i_dbl,
`endif
    output state_t o_state
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      w_next = i_instr_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:     w_next = ST_RESULT;
            ST_RESULT:    w_next = ST_FLAGS;
`ifdef ALU_SEQ_DBL_ADD_EN
            ST_FLAGS:     w_next = i_dbl ? ST_HI_ISSUE : ST_RESP;
            ST_HI_ISSUE:  w_next = ST_HI_RESULT;
            ST_HI_RESULT: w_next = ST_HI_FLAGS;
            ST_HI_FLAGS:  w_next = ST_RESP;
`else
            ST_FLAGS:     w_next = ST_RESP;
`endif
            ST_RESP:      w_next = i_res_ready ? ST_IDLE : ST_RESP;
            default:      w_next = ST_IDLE;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU op per request, holds funsel through the result/flag stages, returns result+flags.
// ALU_SEQ_DBL_ADD_EN adds a 64-bit add as a low ADD pass followed by a high ADC pass.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [3:0]        i_instr_opcode,
    input  logic              i_instr_wide,
    input  logic              i_instr_dbl,
    output logic [4:0]        o_alu_funsel,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [3:0]        i_alu_flags,
    output logic              o_op_hi,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [DATA_W-1:0] o_res_data,
    output logic [DATA_W-1:0] o_res_data_hi,
    output logic [3:0]        o_res_flags,
    output logic              o_busy
);

    state_t            w_state;
    logic              w_accept;
    logic              w_dbl_req;
    logic              w_dbl;
    logic              w_hi_flags;
    logic [4:0]        r_funsel;
    logic [DATA_W-1:0] r_res_data;
    logic [3:0]        r_res_flags;

    alu_seq_fsm u_fsm (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_instr_valid (i_instr_valid),
        .i_res_ready   (i_res_ready),
`ifdef ALU_SEQ_DBL_ADD_EN
        .i_dbl         (w_dbl),
`endif
        .o_state       (w_state)
    );

    assign w_accept = (w_state == ST_IDLE) && i_instr_valid;

`ifdef ALU_SEQ_DBL_ADD_EN
    logic              r_dbl;
    logic              r_op_hi;
    logic [DATA_W-1:0] r_res_data_hi;

    assign w_dbl_req  = i_instr_dbl;
    assign w_dbl      = r_dbl;
    assign w_hi_flags = (w_state == ST_HI_FLAGS);

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_dbl         <= 1'b0;
            r_op_hi       <= 1'b0;
            r_res_data_hi <= '0;
        end else begin
            if (w_accept) r_dbl <= i_instr_dbl;
            r_op_hi <= (w_state == ST_FLAGS && r_dbl) ? 1'b1 : w_hi_flags ? 1'b0 : r_op_hi;
            if (w_state == ST_HI_RESULT) r_res_data_hi <= i_alu_result;
        end
    end

    assign o_op_hi       = r_op_hi;
    assign o_res_data_hi = r_res_data_hi;
`else
    logic w_unused_dbl;

    assign w_unused_dbl  = i_instr_dbl;
    assign w_dbl_req     = 1'b0;
    assign w_dbl         = 1'b0;
    assign w_hi_flags    = 1'b0;
    assign o_op_hi       = 1'b0;
    assign o_res_data_hi = '0;
`endif

    // funsel is only ever changed on state transitions, so it is stable across ISSUE..FLAGS
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_funsel    <= FS_PASSA32;
            r_res_data  <= '0;
            r_res_flags <= '0;
        end else begin
            if (w_accept)
                r_funsel <= w_dbl_req ? FS_ADD32 : {i_instr_wide, i_instr_opcode};
            else if (w_state == ST_FLAGS && w_dbl)
                r_funsel <= FS_ADC32;
            else if (w_state == ST_RESP && i_res_ready)
                r_funsel <= FS_PASSA32;
            if (w_state == ST_RESULT) r_res_data <= i_alu_result;
            if (w_state == ST_FLAGS || w_hi_flags) r_res_flags <= i_alu_flags;
        end
    end

    assign o_instr_ready = (w_state == ST_IDLE) && i_reset_n;
    assign o_alu_funsel  = r_funsel;
    assign o_res_valid   = (w_state == ST_RESP);
    assign o_res_data    = r_res_data;
    assign o_res_flags   = r_res_flags;
    assign o_busy        = (w_state != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench for alu_op_sequencer with a small two-stage ALU model.
// Covers ALU_SEQ_DBL_ADD_EN in either build.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_opcode = '0;
    logic        instr_wide = 1'b0;
    logic        instr_dbl = 1'b0;
    logic [4:0]  alu_funsel;
    logic [31:0] alu_result = '0;
    logic [3:0]  alu_flags = '0;
    logic [3:0]  flags_pre = '0;
    logic        op_hi;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [31:0] res_data_hi;
    logic [3:0]  res_flags;
    logic        busy;
    logic [31:0] a_lo = '0, b_lo = '0, a_hi = '0, b_hi = '0;
    logic [31:0] alu_a, alu_b;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(32)) dut (
        .i_clock        (clk),
        .i_reset_n      (reset_n),
        .i_instr_valid  (instr_valid),
        .o_instr_ready  (instr_ready),
        .i_instr_opcode (instr_opcode),
        .i_instr_wide   (instr_wide),
        .i_instr_dbl    (instr_dbl),
        .o_alu_funsel   (alu_funsel),
        .i_alu_result   (alu_result),
        .i_alu_flags    (alu_flags),
        .o_op_hi        (op_hi),
        .o_res_valid    (res_valid),
        .i_res_ready    (res_ready),
        .o_res_data     (res_data),
        .o_res_data_hi  (res_data_hi),
        .o_res_flags    (res_flags),
        .o_busy         (busy)
    );

    assign alu_a = op_hi ? a_hi : a_lo;
    assign alu_b = op_hi ? b_hi : b_lo;

    // ALU model: result registered one edge after funsel, flags one edge later; carry-in is the flag register
    function automatic logic [35:0] alu_f(input logic [4:0] fs, input logic [31:0] a, b, input logic cin);
        logic [32:0] s;
        logic [31:0] am, bm, r;
        am = fs[4] ? a : {16'h0, a[15:0]};
        bm = fs[4] ? b : {16'h0, b[15:0]};
        case (fs[3:0])
            4'd0:    s = {1'b0, am};
            4'd1:    s = {1'b0, bm};
            4'd4:    s = {1'b0, am} + {1'b0, bm};
            4'd5:    s = {1'b0, am} + {1'b0, bm} + {32'h0, cin};
            4'd6:    s = {1'b0, am} - {1'b0, bm};
            4'd7:    s = {1'b0, am & bm};
            4'd8:    s = {1'b0, am | bm};
            4'd9:    s = {1'b0, am ^ bm};
            default: s = '0;
        endcase
        r = fs[4] ? s[31:0] : {16'h0, s[15:0]};
        return {r == 32'h0, fs[4] ? s[32] : s[16], fs[4] ? r[31] : r[15], 1'b0, r};
    endfunction

    always @(posedge clk) begin
        {flags_pre, alu_result} <= alu_f(alu_funsel, alu_a, alu_b, alu_flags[2]);
        alu_flags <= flags_pre;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request at cycle T and walks it to the first RESP cycle, checking funsel/op_hi each cycle
    task automatic do_op(input string tag, input logic [3:0] op, input logic w, input logic d,
                         input logic [4:0] exp_fs, input logic exp_dbl);
        instr_opcode = op;
        instr_wide   = w;
        instr_dbl    = d;
        instr_valid  = 1'b1;
        chk({tag, " ready_T"}, instr_ready, 1);
        tick;
        instr_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("%s fs_T%0d", tag, i), alu_funsel, exp_fs);
            chk($sformatf("%s ophi_T%0d", tag, i), op_hi, 0);
            chk($sformatf("%s busy_T%0d", tag, i), busy, 1);
            chk($sformatf("%s vld_T%0d", tag, i), res_valid, 0);
            tick;
        end
        if (exp_dbl) begin
            for (int i = 4; i <= 6; i++) begin
                chk($sformatf("%s fs_T%0d", tag, i), alu_funsel, 5'b10101);
                chk($sformatf("%s ophi_T%0d", tag, i), op_hi, 1);
                chk($sformatf("%s vld_T%0d", tag, i), res_valid, 0);
                tick;
            end
        end
        chk({tag, " res_valid"}, res_valid, 1);
        chk({tag, " ready_resp"}, instr_ready, 0);
        chk({tag, " ophi_resp"}, op_hi, 0);
    endtask

    initial begin
        int vld_seen;
        tick;
        tick;
        chk("rst ready", instr_ready, 0);
        chk("rst funsel", alu_funsel, 5'b10000);
        chk("rst op_hi", op_hi, 0);
        chk("rst res_valid", res_valid, 0);
        chk("rst res_data", res_data, 0);
        chk("rst res_data_hi", res_data_hi, 0);
        chk("rst res_flags", res_flags, 0);
        chk("rst busy", busy, 0);
        reset_n = 1'b1;
        #1;
        chk("post rst ready", instr_ready, 1);

        a_lo = 32'h5;
        b_lo = 32'h3;
        do_op("add", 4'd4, 1'b1, 1'b0, 5'b10100, 1'b0);
        chk("add data", res_data, 32'h8);
        chk("add flags", res_flags, 4'b0000);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("add idle busy", busy, 0);
        chk("add idle ready", instr_ready, 1);
        chk("add idle funsel", alu_funsel, 5'b10000);
        chk("add idle vld", res_valid, 0);

        a_lo = 32'h1234;
        b_lo = 32'h1234;
        do_op("sub", 4'd6, 1'b0, 1'b0, 5'b00110, 1'b0);
        chk("sub data", res_data, 32'h0);
        chk("sub Z", res_flags[3], 1);
        a_lo = 32'h5555;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk($sformatf("bp vld %0d", i), res_valid, 1);
            chk($sformatf("bp data %0d", i), res_data, 32'h0);
            chk($sformatf("bp Z %0d", i), res_flags[3], 1);
            chk($sformatf("bp ready %0d", i), instr_ready, 0);
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("bp rel busy", busy, 0);
        chk("bp rel ready", instr_ready, 1);
        chk("bp rel funsel", alu_funsel, 5'b10000);

        a_lo = 32'h7;
        b_lo = 32'h2;
        instr_opcode = 4'd4;
        instr_wide   = 1'b1;
        instr_dbl    = 1'b0;
        instr_valid  = 1'b1;
        tick;
        instr_valid = 1'b0;
        tick;
        chk("rmid busy", busy, 1);
        reset_n = 1'b0;
        tick;
        chk("rmid busy after", busy, 0);
        chk("rmid funsel", alu_funsel, 5'b10000);
        chk("rmid vld", res_valid, 0);
        chk("rmid data", res_data, 0);
        chk("rmid ready", instr_ready, 0);
        reset_n = 1'b1;
        vld_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (res_valid) vld_seen++;
        end
        chk("rmid no resp", vld_seen, 0);
        chk("rmid ready after", instr_ready, 1);

        res_ready = 1'b1;
`ifdef ALU_SEQ_DBL_ADD_EN
        a_lo = 32'hFFFF_FFFF;
        b_lo = 32'h1;
        a_hi = 32'h0;
        b_hi = 32'h0;
        do_op("dbl", 4'd0, 1'b0, 1'b1, 5'b10100, 1'b1);
        chk("dbl data", res_data, 32'h0);
        chk("dbl data_hi", res_data_hi, 32'h1);
        chk("dbl flags", res_flags, 4'b0000);
`else
        a_lo = 32'hF0F0_FF00;
        b_lo = 32'h0FF0_F0F0;
        a_hi = 32'hFFFF_FFFF;
        b_hi = 32'hFFFF_FFFF;
        do_op("and", 4'd7, 1'b1, 1'b1, 5'b10111, 1'b0);
        chk("and data", res_data, 32'h00F0_F000);
        chk("and data_hi", res_data_hi, 32'h0);
        chk("and flags", res_flags, 4'b0000);
`endif
        tick;
        res_ready = 1'b0;
        chk("last idle busy", busy, 0);
        chk("last idle funsel", alu_funsel, 5'b10000);
        chk("last op_hi", op_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
